// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_pkg
// Purpose  : Shared sizes, vector type and FSM state encoding for the
//            MEM-stage vector load/store sequencer.
// Contents : LANES, DATA_W, ADDR_W, IDX_W localparams; vec_t; vmem_state_t.
// Revision : 1.0 - initial release
// ============================================================================
package vec_pkg;

  localparam int LANES  = 16;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int IDX_W  = $clog2(LANES);

  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } vmem_state_t;

endpackage
`default_nettype wire

// File: rtl/vec_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_sequencer_if
// Purpose  : Bundles the request side (from EX/MEM), the single-port data
//            memory bus and the status/result signals of the sequencer.
// Modports : master - the sequencer (drives memory bus, stall, done, result)
//            slave  - pipeline + memory (drives request and read data)
// Signals  : req_valid, req_write, req_base, req_stride, req_wdata,
//            mem_addr, mem_we, mem_wdata, mem_rdata, stall, done,
//            data_vec_mem
// Revision : 1.0 - initial release
// ============================================================================
interface vec_mem_sequencer_if;
  import vec_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_stride;
  vec_t              req_wdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;
  logic              done;
  vec_t              data_vec_mem;

  modport master (
    input  req_valid, req_write, req_base, req_stride, req_wdata, mem_rdata,
    output mem_addr, mem_we, mem_wdata, stall, done, data_vec_mem
  );

  modport slave (
    output req_valid, req_write, req_base, req_stride, req_wdata, mem_rdata,
    input  mem_addr, mem_we, mem_wdata, stall, done, data_vec_mem
  );

endinterface
`default_nettype wire

// File: rtl/vec_mem_sequencer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : vmem_addr_gen
// Purpose  : Lane address generator. Holds the base, stride and lane index
//            of the access in flight and forms base + idx*stride, wrapping
//            modulo 2^ADDR_W.
// Config   : VMEM_STRIDE_EN - when defined the stride is taken from the
//            request; otherwise the stride is fixed at 1 and stride_i is
//            ignored.
// Ports    : clk, rst        clock / asynchronous active-high reset
//            load_i          capture base_i/stride_i and clear the index
//            step_i          advance to the next lane
//            base_i          request base word address
//            stride_i        request lane stride
//            mem_addr_o      address of the current lane
//            idx_o           current lane index
//            last_lane_o     current lane is LANES-1
// Revision : 1.0 - initial release
// ============================================================================
module vmem_addr_gen
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_lane_o
);

  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      base_q <= base_i;
      idx_q  <= '0;
    end else if (step_i) begin
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

`ifdef VMEM_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q <= '0;
    end else if (load_i) begin
      stride_q <= stride_i;
    end
  end

  // Product is evaluated at ADDR_W bits, so overflow simply wraps.
  assign mem_addr_o = base_q + ADDR_W'(idx_q) * stride_q;
`else
  logic w_unused_stride;
  assign w_unused_stride = ^stride_i;

  assign mem_addr_o = base_q + ADDR_W'(idx_q);
`endif

  assign idx_o       = idx_q;
  assign last_lane_o = (idx_q == IDX_W'(LANES - 1));

endmodule
`default_nettype wire

// File: rtl/vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vec_mem_sequencer
// Purpose  : MEM-stage vector load/store engine. Serialises one LANES x
//            DATA_W vector access onto a single-port data memory, one lane
//            per cycle, assembles loaded lanes into data_vec_mem and stalls
//            the upstream pipeline while busy.
// Config   : VMEM_STRIDE_EN - enables strided lane addressing (see
//            vmem_addr_gen); default build is contiguous access only.
// Ports    : clk   clock, posedge
//            rst   asynchronous active-high reset
//            vif   vec_mem_sequencer_if.master:
//                  req_*        request from EX/MEM (stable while stall)
//                  mem_*        single-port memory, rdata 1 cycle latency
//                  stall        freeze IF..EX/MEM
//                  done         one-cycle completion pulse
//                  data_vec_mem assembled load vector to MEM/WB
// Timing   : load  = accept + LANES + 2 cycles to done
//            store = accept + LANES + 1 cycles to done
// Revision : 1.0 - initial release
// ============================================================================
module vec_mem_sequencer
  import vec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  vec_mem_sequencer_if.master   vif
);

  vmem_state_t       state_q;
  logic              write_q;
  vec_t              wdata_q;
  vec_t              data_vec_q;
  logic              mem_we_q;
  logic              done_q;

  logic              w_accept;
  logic              w_step;
  logic [ADDR_W-1:0] w_addr;
  logic [IDX_W-1:0]  w_idx;
  logic              w_last;

  assign w_accept = (state_q == IDLE) & vif.req_valid;
  // The index parks on LANES-1 after the last lane; it is reloaded on accept.
  assign w_step   = (state_q == ACCESS) & ~w_last;

  vmem_addr_gen u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (w_accept),
    .step_i      (w_step),
    .base_i      (vif.req_base),
    .stride_i    (vif.req_stride),
    .mem_addr_o  (w_addr),
    .idx_o       (w_idx),
    .last_lane_o (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      data_vec_q <= '0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vif.req_valid) begin
            state_q  <= ACCESS;
            write_q  <= vif.req_write;
            wdata_q  <= vif.req_wdata;
            mem_we_q <= vif.req_write;
          end
        end
        ACCESS: begin
          // Read data trails the address by one cycle, so the lane captured
          // on this edge is the one addressed in the previous cycle.
          if (!write_q && (w_idx != '0)) begin
            data_vec_q[w_idx - IDX_W'(1)] <= vif.mem_rdata;
          end
          if (w_last) begin
            mem_we_q <= 1'b0;
            if (write_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          data_vec_q[LANES-1] <= vif.mem_rdata;
          state_q             <= DONE;
          done_q              <= 1'b1;
        end
        DONE: begin
          // A request still asserted here is taken in the following IDLE.
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          mem_we_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign vif.mem_addr     = w_addr;
  assign vif.mem_we       = mem_we_q;
  assign vif.mem_wdata    = wdata_q[w_idx];
  assign vif.stall        = w_accept | (state_q == ACCESS) | (state_q == DRAIN);
  assign vif.done         = done_q;
  assign vif.data_vec_mem = data_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_mem_sequencer
// Purpose  : Self-checking bench for vec_mem_sequencer. A table of vector
//            operations is replayed against a single-port memory model;
//            expected lane addresses/data are queued when a request is
//            driven and popped as the DUT issues each lane. A reference
//            memory image gives the expected load vectors. Hand-written
//            sequences cover reset mid-store and back-to-back requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_mem_sequencer;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_mem_sequencer_if vif ();

  vec_mem_sequencer dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  function automatic logic [15:0] pat(input int a);
    return 16'(a) + 16'h00F0;
  endfunction

  // Single-port memory model, read data registered (one-cycle latency).
  bit [15:0] mem [0:65535];
  bit        mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 65536; a++) mem[a] <= pat(a);
      mem_ready <= 1'b1;
    end else if (vif.mem_we) begin
      mem[vif.mem_addr] <= vif.mem_wdata;
    end
    vif.mem_rdata <= mem[vif.mem_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] base;
    logic [15:0] stride;
    logic [15:0] seed;
    bit          hold;
    int          cyc;
  } op_t;

  op_t         ops [8];
  logic [15:0] exp_addr_q [$];
  logic [15:0] exp_wd_q   [$];
  vec_t        exp_vec;
  bit   [15:0] ref_mem [0:65535];

  task automatic run_op(input logic wr, input logic [15:0] base, input logic [15:0] stride,
                        input logic [15:0] seed, input bit hold, input int exp_cyc);
    vec_t        wd;
    logic [15:0] es;
    logic [15:0] a;
    int          cyc;
    bit          seen;
`ifdef VMEM_STRIDE_EN
    es = stride;
`else
    es = 16'd1;
`endif
    for (int i = 0; i < LANES; i++) wd[i] = seed + 16'(i);

    @(negedge clk);
    vif.req_valid  = 1'b1;
    vif.req_write  = wr;
    vif.req_base   = base;
    vif.req_stride = stride;
    vif.req_wdata  = wd;
    #1;
    chk("stall_accept", 256'(vif.stall), 256'(1));
    chk("done_accept", 256'(vif.done), 256'(0));

    for (int i = 0; i < LANES; i++) begin
      a = base + 16'(i) * es;
      exp_addr_q.push_back(a);
      if (wr) begin
        exp_wd_q.push_back(wd[i]);
        ref_mem[a] = wd[i];
      end else begin
        exp_vec[i] = ref_mem[a];
      end
    end

    cyc = 0;
    for (int i = 0; i < LANES; i++) begin
      @(negedge clk);
      cyc++;
      chk("lane_addr", 256'(vif.mem_addr), 256'(exp_addr_q.pop_front()));
      chk("lane_we", 256'(vif.mem_we), 256'(wr));
      if (wr) chk("lane_wdata", 256'(vif.mem_wdata), 256'(exp_wd_q.pop_front()));
      chk("lane_stall", 256'(vif.stall), 256'(1));
      chk("lane_done", 256'(vif.done), 256'(0));
    end

    seen = 1'b0;
    while (!seen && cyc < exp_cyc + 2) begin
      @(negedge clk);
      cyc++;
      if (vif.done) seen = 1'b1;
      else chk("drain_stall", 256'(vif.stall), 256'(1));
    end
    chk("done_seen", 256'(seen), 256'(1));
    chk("latency", 256'(cyc), 256'(exp_cyc));
    chk("done_stall", 256'(vif.stall), 256'(0));
    chk("done_we", 256'(vif.mem_we), 256'(0));
    if (!hold) begin
      vif.req_valid = 1'b0;
      @(negedge clk);
      chk("done_pulse", 256'(vif.done), 256'(0));
      chk("idle_stall", 256'(vif.stall), 256'(0));
    end
    chk("data_vec", 256'(vif.data_vec_mem), 256'(exp_vec));
  endtask

  initial begin
    vif.req_valid  = 1'b0;
    vif.req_write  = 1'b0;
    vif.req_base   = '0;
    vif.req_stride = '0;
    vif.req_wdata  = '0;
    exp_vec        = '0;
    for (int a = 0; a < 65536; a++) ref_mem[a] = pat(a);

    //          wr    base      stride   seed      hold  cycles
    ops[0] = '{1'b0, 16'h0010, 16'd1, 16'h0000, 1'b0, 18};  // contiguous load
    ops[1] = '{1'b1, 16'h0020, 16'd1, 16'hA000, 1'b0, 17};  // contiguous store
    ops[2] = '{1'b0, 16'h0020, 16'd1, 16'h0000, 1'b0, 18};  // read back store
    ops[3] = '{1'b0, 16'hFFF8, 16'd1, 16'h0000, 1'b0, 18};  // wrapping load
    ops[4] = '{1'b1, 16'hFFF8, 16'd1, 16'h5500, 1'b0, 17};  // wrapping store
    ops[5] = '{1'b0, 16'h0000, 16'd4, 16'h0000, 1'b0, 18};  // stride 4 load
    ops[6] = '{1'b1, 16'h0100, 16'd3, 16'h1234, 1'b1, 17};  // held through DONE
    ops[7] = '{1'b0, 16'h0100, 16'd3, 16'h0000, 1'b0, 18};  // back-to-back

    repeat (3) @(negedge clk);
    chk("rst_addr", 256'(vif.mem_addr), 256'(0));
    chk("rst_we", 256'(vif.mem_we), 256'(0));
    chk("rst_wdata", 256'(vif.mem_wdata), 256'(0));
    chk("rst_done", 256'(vif.done), 256'(0));
    chk("rst_stall", 256'(vif.stall), 256'(0));
    chk("rst_data", 256'(vif.data_vec_mem), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 256'(vif.stall), 256'(0));

    for (int t = 0; t < 8; t++)
      run_op(ops[t].wr, ops[t].base, ops[t].stride, ops[t].seed, ops[t].hold, ops[t].cyc);

    // Reset asserted while lane 7 of a store is on the bus.
    @(negedge clk);
    vif.req_valid  = 1'b1;
    vif.req_write  = 1'b1;
    vif.req_base   = 16'h0040;
    vif.req_stride = 16'd1;
    for (int i = 0; i < LANES; i++) vif.req_wdata[i] = 16'h7700 + 16'(i);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_seq_addr", 256'(vif.mem_addr), 256'(16'h0040 + 16'(i)));
      chk("rst_seq_we", 256'(vif.mem_we), 256'(1));
      if (i < 7) ref_mem[16'h0040 + 16'(i)] = 16'h7700 + 16'(i);
    end
    rst           = 1'b1;
    vif.req_valid = 1'b0;
    #1;
    chk("abort_we", 256'(vif.mem_we), 256'(0));
    chk("abort_stall", 256'(vif.stall), 256'(0));
    chk("abort_done", 256'(vif.done), 256'(0));
    chk("abort_data", 256'(vif.data_vec_mem), 256'(0));
    exp_vec = '0;
    @(negedge clk);
    chk("abort_we_hold", 256'(vif.mem_we), 256'(0));
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_idle_we", 256'(vif.mem_we), 256'(0));
      chk("abort_idle_stall", 256'(vif.stall), 256'(0));
    end
    // Lanes 0..6 landed, lanes 7..15 must be untouched.
    run_op(1'b0, 16'h0040, 16'd1, 16'h0000, 1'b0, 18);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
